mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum mem_ready_i wait in cycles before an access is aborted (1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports if_req_i (in, 1), if_addr_i (in, 24) and if_ack_o (out, 1): the instruction-fetch request; fetches are always word reads.
REQ-005 SHALL have ports d_req_i (in, 1), d_we_i (in, 1), d_word_i (in, 1), d_addr_i (in, 24) and d_wdata_i (in, 16): the data-port request; d_word_i=1 selects a word access, 0 a byte access.
REQ-006 SHALL have ports d_ack_o (out, 1) and d_rdata_o (out, 16): data-port completion.
REQ-007 SHALL have ports mem_addr_o (out, 24), mem_re_o (out, 1), mem_we_o (out, 1), mem_be_o (out, 2), mem_data_o (out, 16), mem_data_i (in, 16) and mem_ready_i (in, 1): the shared memory bus.
REQ-008 SHALL have ports if_rdata_o (out, 16), err_o (out, 1) and busy_o (out, 1): fetch read data, timeout flag, and high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-010 IDLE: if a request is pending, SHALL latch the granted port's address, command and write data, and enter ACCESS on the next edge.
REQ-011 ACCESS: SHALL drive mem_re_o or mem_we_o from the registered command and hold all bus outputs stable until mem_ready_i is sampled high.
REQ-012 ACCESS: on mem_ready_i high, SHALL capture read data and enter RESP.
REQ-013 RESP: SHALL pulse the granted port's ack for exactly one cycle, then return to IDLE; minimum latency is request-to-ack = 3 cycles with zero wait states.
REQ-014 Requests are level signals; each requester SHALL hold its request and operands stable until its ack.
REQ-015 An IDLE request SHALL be granted in the same cycle it is sampled; no back-to-back grant without passing through IDLE.
REQ-016 Byte access, big-endian: even address SHALL give mem_be_o=2'b10 with the byte on [15:8]; odd address SHALL give 2'b01 with the byte on [7:0].
REQ-017 Byte write SHALL replicate d_wdata_i[7:0] on both bus lanes.
REQ-018 Byte read SHALL return the selected lane zero-extended to 16 bits.
REQ-019 Word access SHALL drive mem_be_o=2'b11 and the full word; address bit 0 is passed through unmodified.
REQ-020 A wait counter SHALL clear on ACCESS entry and increment each cycle in ACCESS; when it reaches TIMEOUT without ready, the FSM SHALL enter RESP with err_o=1 during the ack cycle and read data 16'h0000.
REQ-021 err_o SHALL be 0 in every cycle except a timed-out ack cycle.
REQ-022 mem_re_o and mem_we_o SHALL never be high simultaneously and SHALL be low outside ACCESS.
REQ-023 if_rdata_o and d_rdata_o SHALL hold their last value until the next ack on that port.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter 0, ack/err/busy/re/we 0, mem_be_o 2'b00, and address/data outputs 0, including mid-ACCESS (access abandoned, no ack).
REQ-025 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-026 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not served last (a last-grant flag resetting to fetch-served, so data wins first).
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN, the data port SHALL have fixed priority over fetch on simultaneous requests.

Structure
REQ-028 FSM state enum, byte-enable constants and the default TIMEOUT SHALL live in the shared CPU package.
REQ-029 Lane steering (REQ-016..019) SHALL be a sub-module mem_lane_steer, purely combinational; the FSM and counter remain in mem_arbiter.

Verification
REQ-030 Fetch 0x000100, ready after 2 waits, mem_data_i=16'hBEEF -> if_ack_o pulses one cycle 5 cycles after request, if_rdata_o=16'hBEEF.
REQ-031 Byte read at 0x000201, mem_data_i=16'h12AB, zero waits -> mem_be_o=2'b01, d_rdata_o=16'h00AB; at 0x000200 -> 2'b10, 16'h0012.
REQ-032 Byte write 0x55 to 0x000300 -> mem_we_o=1, mem_be_o=2'b10, mem_data_o=16'h5555.
REQ-033 Both requests asserted together for 4 transactions -> fixed mode: data granted while held; round-robin mode: grants alternate D,F,D,F.
REQ-034 TIMEOUT=4, mem_ready_i held low -> ack after 4 ACCESS cycles with err_o=1, rdata 16'h0000.
REQ-035 rst_n pulled low during ACCESS -> bus strobes drop immediately, no ack, a fresh request after release completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM states,
// byte-enable encodings and the default access timeout.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Big-endian lanes: the even byte lives on [15:8]
  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared memory bus between the arbiter (master) and the memory (slave).
// Signal suffixes are given from the arbiter's point of view.
interface mem_arbiter_if;
  logic [23:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i;
  logic        mem_ready_i;

  modport master (
    output mem_addr_o, mem_re_o, mem_we_o, mem_be_o, mem_data_o,
    input  mem_data_i, mem_ready_i
  );

  modport slave (
    input  mem_addr_o, mem_re_o, mem_we_o, mem_be_o, mem_data_o,
    output mem_data_i, mem_ready_i
  );
endinterface

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering for the 16-bit big-endian bus: byte
// enables, write-lane replication and read-lane extraction.
module mem_lane_steer
  import mem_arbiter_pkg::*;
(
  input  logic        word_i,
  input  logic        addr0_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] bus_rdata_i,
  output logic [1:0]  be_o,
  output logic [15:0] bus_wdata_o,
  output logic [15:0] rdata_o
);

  always_comb begin
    if (word_i) begin
      be_o        = BE_WORD;
      bus_wdata_o = wdata_i;
      rdata_o     = bus_rdata_i;
    end else begin
      be_o        = addr0_i ? BE_LO : BE_HI;
      // The byte goes on both lanes so the enable alone picks the target
      bus_wdata_o = {wdata_i[7:0], wdata_i[7:0]};
      rdata_o     = {8'h00, (addr0_i ? bus_rdata_i[7:0] : bus_rdata_i[15:8])};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory bus with wait-state timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is data-over-fetch priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [23:0] if_addr_i,
  output logic        if_ack_o,
  output logic [15:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic        d_word_i,
  input  logic [23:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [15:0] d_rdata_o,
  output logic        err_o,
  output logic        busy_o,
  mem_arbiter_if.master mem
);

  arb_state_e  state_q;
  logic [7:0]  cnt_q;
  logic        gnt_data_q;
  logic        re_q, we_q, if_ack_q, d_ack_q, err_q, busy_q;
  logic [1:0]  be_q;
  logic [23:0] addr_q;
  logic [15:0] wdata_q, if_rdata_q, d_rdata_q;

  logic        pick_data_d, sel_data_d, timeout_d, d_write_d;
  logic [1:0]  steer_be;
  logic [15:0] steer_wdata, steer_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q;

  // Resets to "fetch served last" so data wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 last_data_q <= 1'b0;
    else if (state_q == ST_RESP) last_data_q <= gnt_data_q;
  end

  assign pick_data_d = d_req_i && (!if_req_i || !last_data_q);
`else
  assign pick_data_d = d_req_i;
`endif

  // In IDLE steer the candidate; afterwards the granted port's held operands
  assign sel_data_d = (state_q == ST_IDLE) ? pick_data_d : gnt_data_q;
  assign d_write_d  = pick_data_d && d_we_i;
  assign timeout_d  = (cnt_q == 8'(TIMEOUT - 1));

  mem_lane_steer u_steer (
    .word_i      (sel_data_d ? d_word_i : 1'b1),
    .addr0_i     (sel_data_d ? d_addr_i[0] : if_addr_i[0]),
    .wdata_i     (d_wdata_i),
    .bus_rdata_i (mem.mem_data_i),
    .be_o        (steer_be),
    .bus_wdata_o (steer_wdata),
    .rdata_o     (steer_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_data_q <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= BE_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_req_i || d_req_i) begin
            state_q    <= ST_ACCESS;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            gnt_data_q <= pick_data_d;
            addr_q     <= pick_data_d ? d_addr_i : if_addr_i;
            we_q       <= d_write_d;
            re_q       <= !d_write_d;
            be_q       <= steer_be;
            wdata_q    <= d_write_d ? steer_wdata : '0;
          end
        end
        ST_ACCESS: begin
          if (mem.mem_ready_i || timeout_d) begin
            state_q  <= ST_RESP;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= BE_NONE;
            err_q    <= !mem.mem_ready_i;
            if_ack_q <= !gnt_data_q;
            d_ack_q  <= gnt_data_q;
            // A completed write leaves the data-port read register untouched
            if (!gnt_data_q)
              if_rdata_q <= mem.mem_ready_i ? steer_rdata : '0;
            else if (!we_q || !mem.mem_ready_i)
              d_rdata_q <= mem.mem_ready_i ? steer_rdata : '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ack_o       = if_ack_q;
  assign d_ack_o        = d_ack_q;
  assign err_o          = err_q;
  assign busy_o         = busy_q;
  assign if_rdata_o     = if_rdata_q;
  assign d_rdata_o      = d_rdata_q;
  assign mem.mem_addr_o = addr_q;
  assign mem.mem_re_o   = re_q;
  assign mem.mem_we_o   = we_q;
  assign mem.mem_be_o   = be_q;
  assign mem.mem_data_o = wdata_q;

endmodule
